dmi_regbus_bridge: RTL and testbench

- Downstream consumer of the simulation debug transport's DMI request/response channel.
- Decodes each DMI request (op NOP/READ/WRITE) into one transaction on a simple valid/ready register bus toward debug-module registers.
- Returns exactly one DMI response per accepted request, and guards against a hung bus with a timeout.

---
 rtl/dmi_pkg.sv | 23 ++
 rtl/dmi_regbus_bridge_if.sv | 52 +++++
 rtl/dmi_timeout_ctr.sv | 32 +++
 rtl/dmi_regbus_bridge.sv | 146 ++++++++++++++
 tb/tb_dmi_regbus_bridge.sv | 334 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmi_pkg.sv
// Shared definitions for the DMI-to-register-bus bridge: opcode and
// response encodings, the bridge FSM states and default bus widths.
package dmi_pkg;

    localparam int DMI_ADDR_W = 7;
    localparam int DMI_DATA_W = 32;

    localparam logic [1:0] DMI_OP_NOP   = 2'd0;
    localparam logic [1:0] DMI_OP_READ  = 2'd1;
    localparam logic [1:0] DMI_OP_WRITE = 2'd2;

    localparam logic [1:0] DMI_RESP_OK   = 2'd0;
    localparam logic [1:0] DMI_RESP_FAIL = 2'd2;
    localparam logic [1:0] DMI_RESP_BUSY = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        BUS_REQ,
        BUS_WAIT,
        RESP
    } dmi_state_e;

endpackage

// File: rtl/dmi_regbus_bridge_if.sv
// Handshake and bus signals of the bridge. The slave modport is the bridge
// itself; the master modport is the environment (debug transport on the
// request/response side plus the register bus on the other side).
interface dmi_regbus_bridge_if
    import dmi_pkg::*;
#(
    parameter int ADDR_W = DMI_ADDR_W,
    parameter int DATA_W = DMI_DATA_W
);

    logic              debug_req_valid;
    logic              debug_req_ready;
    logic [ADDR_W-1:0] debug_req_bits_addr;
    logic [1:0]        debug_req_bits_op;
    logic [DATA_W-1:0] debug_req_bits_data;
    logic              debug_resp_valid;
    logic              debug_resp_ready;
    logic [1:0]        debug_resp_bits_resp;
    logic [DATA_W-1:0] debug_resp_bits_data;

    logic              bus_req_valid;
    logic              bus_req_ready;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic              bus_ack;
    logic              bus_err;
    logic [DATA_W-1:0] bus_rdata;
    logic              bus_abort;
    logic              err_sticky;

    modport slave (
        input  debug_req_valid, debug_req_bits_addr, debug_req_bits_op, debug_req_bits_data,
        output debug_req_ready,
        output debug_resp_valid, debug_resp_bits_resp, debug_resp_bits_data,
        input  debug_resp_ready,
        output bus_req_valid, bus_we, bus_addr, bus_wdata,
        input  bus_req_ready, bus_ack, bus_err, bus_rdata,
        output bus_abort, err_sticky
    );

    modport master (
        output debug_req_valid, debug_req_bits_addr, debug_req_bits_op, debug_req_bits_data,
        input  debug_req_ready,
        input  debug_resp_valid, debug_resp_bits_resp, debug_resp_bits_data,
        output debug_resp_ready,
        input  bus_req_valid, bus_we, bus_addr, bus_wdata,
        output bus_req_ready, bus_ack, bus_err, bus_rdata,
        input  bus_abort, err_sticky
    );

endinterface

// File: rtl/dmi_timeout_ctr.sv
// Cycle counter guarding the wait for a register-bus acknowledge.
// Expire is raised once the counter has reached TIMEOUT-1.
module dmi_timeout_ctr #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    logic [CNT_W-1:0] count_q;

    // Clear dominates; the count never wraps because the owner leaves the wait state at LAST.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable) begin
            count_q <= count_q + ONE;
        end
    end

    assign expire = (count_q == LAST);

endmodule

// File: rtl/dmi_regbus_bridge.sv
// Turns each DMI request into at most one register-bus transaction and
// returns exactly one DMI response, aborting the bus wait after TIMEOUT cycles.
module dmi_regbus_bridge
    import dmi_pkg::*;
#(
    parameter int ADDR_W  = DMI_ADDR_W,
    parameter int DATA_W  = DMI_DATA_W,
    parameter int TIMEOUT = 255
) (
    input logic clk,
    input logic reset,
    dmi_regbus_bridge_if.slave bif
);

    dmi_state_e state_q, state_d;

    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [DATA_W-1:0] wdata_q;
    logic [1:0]        resp_q, resp_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              abort_q, abort_d;
    logic              sticky_q;
    logic              accept;
    logic              enter_resp;
    logic              timer_clear;
    logic              timer_en;
    logic              timer_expire;

    assign accept      = bif.debug_req_valid && (state_q == IDLE);
    assign enter_resp  = (state_d == RESP) && (state_q != RESP);
    assign timer_clear = (state_q != BUS_WAIT);

    dmi_timeout_ctr #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout (
        .clk   (clk),
        .reset (reset),
        .clear (timer_clear),
        .enable(timer_en),
        .expire(timer_expire)
    );

    // Next-state and response selection; an ack in the expiry cycle beats the timeout.
    always_comb begin
        state_d  = state_q;
        resp_d   = resp_q;
        rdata_d  = rdata_q;
        abort_d  = 1'b0;
        timer_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (bif.debug_req_bits_op == DMI_OP_NOP) begin
                        state_d = RESP;
                        resp_d  = DMI_RESP_OK;
                        rdata_d = '0;
                    end else if ((bif.debug_req_bits_op == DMI_OP_READ) ||
                                 (bif.debug_req_bits_op == DMI_OP_WRITE)) begin
                        state_d = BUS_REQ;
                    end else begin
                        state_d = RESP;
                        resp_d  = DMI_RESP_FAIL;
                        rdata_d = '0;
                    end
                end
            end
            BUS_REQ: begin
                if (bif.bus_req_ready) begin
                    state_d = BUS_WAIT;
                end
            end
            BUS_WAIT: begin
                if (bif.bus_ack) begin
                    state_d = RESP;
                    resp_d  = bif.bus_err ? DMI_RESP_FAIL : DMI_RESP_OK;
                    rdata_d = (!we_q && !bif.bus_err) ? bif.bus_rdata : '0;
                end else if (timer_expire) begin
                    state_d = RESP;
                    resp_d  = DMI_RESP_BUSY;
                    rdata_d = '0;
                    abort_d = 1'b1;
                end else begin
                    timer_en = 1'b1;
                end
            end
            RESP: begin
                if (bif.debug_resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture the request so the bus side sees stable values while it stalls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
        end else if (accept) begin
            addr_q  <= bif.debug_req_bits_addr;
            we_q    <= (bif.debug_req_bits_op == DMI_OP_WRITE);
            wdata_q <= bif.debug_req_bits_data;
        end
    end

    // Response fields, abort pulse and the sticky error flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_q   <= DMI_RESP_OK;
            rdata_q  <= '0;
            abort_q  <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            resp_q  <= resp_d;
            rdata_q <= rdata_d;
            abort_q <= abort_d;
            if (enter_resp && (resp_d != DMI_RESP_OK)) begin
                sticky_q <= 1'b1;
            end
        end
    end

    assign bif.debug_req_ready      = (state_q == IDLE);
    assign bif.debug_resp_valid     = (state_q == RESP);
    assign bif.debug_resp_bits_resp = resp_q;
    assign bif.debug_resp_bits_data = rdata_q;
    assign bif.bus_req_valid        = (state_q == BUS_REQ);
    assign bif.bus_we               = (state_q == BUS_REQ) && we_q;
    assign bif.bus_addr             = (state_q == BUS_REQ) ? addr_q : '0;
    assign bif.bus_wdata            = (state_q == BUS_REQ) ? wdata_q : '0;
    assign bif.bus_abort            = abort_q;
    assign bif.err_sticky           = sticky_q;

endmodule

// File: tb/tb_dmi_regbus_bridge.sv
// Scoreboard bench for dmi_regbus_bridge: directed cases followed by random
// transactions, with expected responses derived from a behavioural model.
module tb_dmi_regbus_bridge;
    import dmi_pkg::*;

    localparam int ADDR_W  = 7;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 4;

    typedef struct {
        logic [1:0]        op;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        int                req_stall;
        int                ack_delay;
        logic              err;
        logic [DATA_W-1:0] rdata;
        int                resp_stall;
    } txn_t;

    typedef struct {
        logic [1:0]        resp;
        logic [DATA_W-1:0] data;
        int                abort;
        int                latency;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;

    exp_t exp_q[$];
    int   total_checks = 0;
    int   bad_checks = 0;
    int   abort_cnt = 0;
    int   busreq_cnt = 0;
    bit   model_sticky = 1'b0;

    always #5 clk = ~clk;

    dmi_regbus_bridge_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bif ();

    dmi_regbus_bridge #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bif  (bif.slave)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total_checks++;
        if (actual !== expected) begin
            bad_checks++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic finishRun();
        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    endtask

    // Reference model: response code, data, abort and response latency from the spec rules.
    function automatic exp_t expectOf(input txn_t t);
        exp_t e;
        e.resp    = DMI_RESP_OK;
        e.data    = '0;
        e.abort   = 0;
        e.latency = 1;
        if (t.op == DMI_OP_READ || t.op == DMI_OP_WRITE) begin
            if (t.ack_delay >= 1 && t.ack_delay <= TIMEOUT) begin
                e.resp    = t.err ? DMI_RESP_FAIL : DMI_RESP_OK;
                e.data    = (t.op == DMI_OP_READ && !t.err) ? t.rdata : '0;
                e.latency = t.req_stall + 2 + t.ack_delay;
            end else begin
                e.resp    = DMI_RESP_BUSY;
                e.abort   = 1;
                e.latency = t.req_stall + 2 + TIMEOUT;
            end
        end else if (t.op != DMI_OP_NOP) begin
            e.resp = DMI_RESP_FAIL;
        end
        return e;
    endfunction

    function automatic txn_t mk(input logic [1:0] op, input logic [ADDR_W-1:0] addr,
                                input logic [DATA_W-1:0] wdata, input int req_stall,
                                input int ack_delay, input logic err,
                                input logic [DATA_W-1:0] rdata, input int resp_stall);
        txn_t t;
        t.op = op; t.addr = addr; t.wdata = wdata; t.req_stall = req_stall;
        t.ack_delay = ack_delay; t.err = err; t.rdata = rdata; t.resp_stall = resp_stall;
        return t;
    endfunction

    // Monitor: counts bus activity and checks every response handshake against the scoreboard.
    always @(negedge clk) begin
        if (!reset) begin
            if (bif.bus_abort) abort_cnt++;
            if (bif.bus_req_valid) busreq_cnt++;
            if (bif.debug_resp_valid && bif.debug_resp_ready) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_resp", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    checkOutput("resp_code", 64'(bif.debug_resp_bits_resp), 64'(e.resp));
                    checkOutput("resp_data", 64'(bif.debug_resp_bits_data), 64'(e.data));
                end
            end
        end
    end

    // Drives one complete transaction; called at posedge+1 with the bridge idle.
    task automatic applyStimulus(input txn_t t);
        exp_t e;
        int   abort_base;
        int   busreq_base;
        int   guard;
        bit   uses_bus;
        e = expectOf(t);
        uses_bus = (t.op == DMI_OP_READ || t.op == DMI_OP_WRITE);
        exp_q.push_back(e);
        if (e.resp != DMI_RESP_OK) model_sticky = 1'b1;
        abort_base  = abort_cnt;
        busreq_base = busreq_cnt;

        bif.debug_req_valid     = 1'b1;
        bif.debug_req_bits_addr = t.addr;
        bif.debug_req_bits_op   = t.op;
        bif.debug_req_bits_data = t.wdata;
        guard = 0;
        while (!bif.debug_req_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!bif.debug_req_ready) begin
            checkOutput("req_ready_wait", 64'd0, 64'd1);
            finishRun();
        end
        @(posedge clk); #1;
        bif.debug_req_valid = 1'b0;

        fork
            begin
                if (uses_bus) begin
                    checkOutput("bus_req_valid", 64'(bif.bus_req_valid), 64'd1);
                    checkOutput("bus_we", 64'(bif.bus_we), 64'(t.op == DMI_OP_WRITE));
                    checkOutput("bus_addr", 64'(bif.bus_addr), 64'(t.addr));
                    if (t.op == DMI_OP_WRITE) checkOutput("bus_wdata", 64'(bif.bus_wdata), 64'(t.wdata));
                    repeat (t.req_stall) begin
                        @(posedge clk); #1;
                        checkOutput("bus_hold_valid", 64'(bif.bus_req_valid), 64'd1);
                        checkOutput("bus_hold_addr", 64'(bif.bus_addr), 64'(t.addr));
                        if (t.op == DMI_OP_WRITE) checkOutput("bus_hold_wdata", 64'(bif.bus_wdata), 64'(t.wdata));
                    end
                    bif.bus_req_ready = 1'b1;
                    @(posedge clk); #1;
                    bif.bus_req_ready = 1'b0;
                    if (t.ack_delay > 0) begin
                        if (t.ack_delay > 1) begin
                            repeat (t.ack_delay - 1) @(posedge clk);
                            #1;
                        end
                        bif.bus_ack   = 1'b1;
                        bif.bus_err   = t.err;
                        bif.bus_rdata = t.rdata;
                        @(posedge clk); #1;
                        bif.bus_ack   = 1'b0;
                        bif.bus_err   = 1'b0;
                        bif.bus_rdata = $urandom;
                    end
                end
            end
            begin
                int lat;
                lat = 1;
                while (!bif.debug_resp_valid && lat < 60) begin
                    @(posedge clk); #1;
                    lat++;
                end
                if (!bif.debug_resp_valid) begin
                    checkOutput("resp_valid_wait", 64'd0, 64'd1);
                    finishRun();
                end
                checkOutput("resp_latency", 64'(lat), 64'(e.latency));
                repeat (t.resp_stall) begin
                    @(posedge clk); #1;
                    checkOutput("resp_hold_valid", 64'(bif.debug_resp_valid), 64'd1);
                    checkOutput("resp_hold_code", 64'(bif.debug_resp_bits_resp), 64'(e.resp));
                    checkOutput("resp_hold_data", 64'(bif.debug_resp_bits_data), 64'(e.data));
                    checkOutput("req_ready_in_resp", 64'(bif.debug_req_ready), 64'd0);
                end
                bif.debug_resp_ready = 1'b1;
                @(posedge clk); #1;
                bif.debug_resp_ready = 1'b0;
            end
        join

        checkOutput("abort_pulses", 64'(abort_cnt - abort_base), 64'(e.abort));
        checkOutput("busreq_cycles", 64'(busreq_cnt - busreq_base), uses_bus ? 64'(t.req_stall + 1) : 64'd0);
        checkOutput("err_sticky", 64'(bif.err_sticky), 64'(model_sticky));
        checkOutput("idle_after_resp", 64'(bif.debug_req_ready), 64'd1);
    endtask

    // Checks everything the bridge drives against its reset values.
    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_req_ready"}, 64'(bif.debug_req_ready), 64'd1);
        checkOutput({tag, "_resp_valid"}, 64'(bif.debug_resp_valid), 64'd0);
        checkOutput({tag, "_resp_code"}, 64'(bif.debug_resp_bits_resp), 64'd0);
        checkOutput({tag, "_resp_data"}, 64'(bif.debug_resp_bits_data), 64'd0);
        checkOutput({tag, "_bus_valid"}, 64'(bif.bus_req_valid), 64'd0);
        checkOutput({tag, "_bus_we"}, 64'(bif.bus_we), 64'd0);
        checkOutput({tag, "_bus_addr"}, 64'(bif.bus_addr), 64'd0);
        checkOutput({tag, "_bus_wdata"}, 64'(bif.bus_wdata), 64'd0);
        checkOutput({tag, "_abort"}, 64'(bif.bus_abort), 64'd0);
        checkOutput({tag, "_sticky"}, 64'(bif.err_sticky), 64'd0);
    endtask

    initial begin
        txn_t t;
        bif.debug_req_valid     = 1'b0;
        bif.debug_req_bits_addr = '0;
        bif.debug_req_bits_op   = '0;
        bif.debug_req_bits_data = '0;
        bif.debug_resp_ready    = 1'b0;
        bif.bus_req_ready       = 1'b0;
        bif.bus_ack             = 1'b0;
        bif.bus_err             = 1'b0;
        bif.bus_rdata           = '0;

        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkResetOutputs("reset");
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        checkResetOutputs("post_reset");

        $display("[TB] directed transactions");
        applyStimulus(mk(DMI_OP_NOP, 7'h10, 32'h0, 0, 0, 1'b0, 32'h0, 0));
        applyStimulus(mk(DMI_OP_READ, 7'h11, 32'h0, 0, 1, 1'b0, 32'hDEADBEEF, 0));
        applyStimulus(mk(DMI_OP_WRITE, 7'h04, 32'h80000001, 5, 1, 1'b1, 32'h12345678, 1));
        applyStimulus(mk(DMI_OP_READ, 7'h05, 32'h0, 0, TIMEOUT + 2, 1'b0, 32'hCAFEF00D, 3));
        applyStimulus(mk(DMI_OP_READ, 7'h06, 32'h0, 1, TIMEOUT, 1'b0, 32'hA5A5A5A5, 0));
        applyStimulus(mk(DMI_OP_READ, 7'h07, 32'h0, 0, 0, 1'b0, 32'h0, 0));
        applyStimulus(mk(2'd3, 7'h08, 32'hFFFFFFFF, 0, 0, 1'b0, 32'h0, 2));

        $display("[TB] response backpressure with request held valid");
        exp_q.push_back('{resp: DMI_RESP_OK, data: '0, abort: 0, latency: 1});
        bif.debug_req_valid     = 1'b1;
        bif.debug_req_bits_addr = 7'h22;
        bif.debug_req_bits_op   = DMI_OP_NOP;
        bif.debug_req_bits_data = 32'h0;
        checkOutput("bp_ready_before", 64'(bif.debug_req_ready), 64'd1);
        @(posedge clk); #1;
        bif.debug_req_bits_addr = 7'h23;
        bif.debug_req_bits_op   = 2'd3;
        checkOutput("bp_resp_valid", 64'(bif.debug_resp_valid), 64'd1);
        repeat (10) begin
            @(posedge clk); #1;
            checkOutput("bp_req_ready_low", 64'(bif.debug_req_ready), 64'd0);
            checkOutput("bp_resp_code", 64'(bif.debug_resp_bits_resp), 64'(DMI_RESP_OK));
            checkOutput("bp_resp_data", 64'(bif.debug_resp_bits_data), 64'd0);
        end
        exp_q.push_back('{resp: DMI_RESP_FAIL, data: '0, abort: 0, latency: 1});
        model_sticky = 1'b1;
        bif.debug_resp_ready = 1'b1;
        @(posedge clk); #1;
        bif.debug_resp_ready = 1'b0;
        checkOutput("bp_no_accept_in_hs", 64'(bif.debug_req_ready), 64'd1);
        checkOutput("bp_resp_dropped", 64'(bif.debug_resp_valid), 64'd0);
        @(posedge clk); #1;
        bif.debug_req_valid = 1'b0;
        checkOutput("bp_next_resp_valid", 64'(bif.debug_resp_valid), 64'd1);
        bif.debug_resp_ready = 1'b1;
        @(posedge clk); #1;
        bif.debug_resp_ready = 1'b0;
        checkOutput("bp_sticky", 64'(bif.err_sticky), 64'(model_sticky));

        $display("[TB] random transactions");
        for (int i = 0; i < 40; i++) begin
            int r;
            r = $urandom_range(0, 9);
            t.op = (r == 0) ? DMI_OP_NOP : (r == 1) ? 2'd3 : (r < 6) ? DMI_OP_READ : DMI_OP_WRITE;
            t.addr       = ADDR_W'($urandom_range(0, 127));
            t.wdata      = $urandom;
            t.req_stall  = $urandom_range(0, 3);
            t.ack_delay  = $urandom_range(0, TIMEOUT + 2);
            t.err        = ($urandom_range(0, 3) == 0);
            t.rdata      = $urandom;
            t.resp_stall = $urandom_range(0, 3);
            applyStimulus(t);
        end

        $display("[TB] reset during bus wait");
        bif.debug_req_valid     = 1'b1;
        bif.debug_req_bits_addr = 7'h33;
        bif.debug_req_bits_op   = DMI_OP_READ;
        @(posedge clk); #1;
        bif.debug_req_valid = 1'b0;
        bif.bus_req_ready   = 1'b1;
        @(posedge clk); #1;
        bif.bus_req_ready = 1'b0;
        @(posedge clk); #2;
        reset = 1'b1;
        model_sticky = 1'b0;
        #1;
        checkResetOutputs("mid_reset");
        @(negedge clk);
        reset = 1'b0;
        bif.debug_resp_ready = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            checkOutput("after_reset_req_ready", 64'(bif.debug_req_ready), 64'd1);
            checkOutput("after_reset_no_resp", 64'(bif.debug_resp_valid), 64'd0);
        end
        bif.debug_resp_ready = 1'b0;
        applyStimulus(mk(DMI_OP_READ, 7'h12, 32'h0, 0, 1, 1'b0, 32'h0BADF00D, 0));

        checkOutput("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        finishRun();
    end

    initial begin
        #200000;
        checkOutput("global_time_limit", 64'd0, 64'd1);
        finishRun();
    end

endmodule
